// File: rtl/jtkiwi_romslot.sv
// jtkiwi_romslot: SDRAM-side responder for the 32-bit graphics ROM fetch port.
// Each 32-bit word miss becomes one two-beat 16-bit SDRAM read. The assembled
// word is kept in a one-entry cache so that repeated fetches hit at once.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   rom_cs, rom_addr          client request and 32-bit word address
//   rom_data, rom_ok          cached word and registered hit flag
//   sdram_req, sdram_addr     read request (held until ack) and 16-bit word address
//   sdram_ack                 request accepted pulse
//   sdram_dok, sdram_din      data beat strobe and beat data
module jtkiwi_romslot #(
  parameter logic [20:0] OFFSET = 21'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_cs,
  input  logic [17:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        rom_ok,
  output logic        sdram_req,
  output logic [20:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dok,
  input  logic [15:0] sdram_din
);

  localparam int unsigned AW  = 18;
  localparam int unsigned SAW = 21;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pend_q, pend_d;
  logic [AW-1:0]   tag_q, tag_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [DW-1:0]   data_q, data_d;
  logic            ok_q, ok_d;
  logic            req_q, req_d;
  logic [SAW-1:0]  addr_q, addr_d;
  logic            hit_c;

  assign hit_c = rom_cs & valid_q & (tag_q == rom_addr);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      buf_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; strobes are honoured in the cycle a state is entered
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rom_cs && !hit_c) state_d = ST_REQ;
      ST_REQ:   if (sdram_ack)        state_d = ST_BEAT0;
      ST_BEAT0: if (sdram_dok)        state_d = ST_BEAT1;
      ST_BEAT1: if (sdram_dok)        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; a started fetch always runs to completion
  always_comb begin
    pend_d  = pend_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    data_d  = data_q;
    ok_d    = hit_c;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit_c) begin
          pend_d = rom_addr;
          req_d  = 1'b1;
          // OFFSET add wraps at 2^21 by truncation
          addr_d = SAW'(OFFSET + {2'b00, rom_addr, 1'b0});
        end
      end
      ST_REQ: begin
        if (sdram_ack) req_d = 1'b0;
      end
      ST_BEAT0: begin
        if (sdram_dok) buf_d = sdram_din;
      end
      ST_BEAT1: begin
        if (sdram_dok) begin
          data_d  = {sdram_din, buf_q};
          tag_d   = pend_q;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rom_data   = data_q;
  assign rom_ok     = ok_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtkiwi_romslot.sv
// Directed testbench for jtkiwi_romslot: one instance with OFFSET 21'h10000
// for the main sequences and one with OFFSET 21'h1FFFFE for the wrap case.
module tb_jtkiwi_romslot;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, ack, dok;
  logic [17:0] addr;
  logic [15:0] din;
  logic [31:0] data;
  logic        ok, req;
  logic [20:0] saddr;

  logic        w_cs, w_ack, w_dok;
  logic [17:0] w_addr;
  logic [15:0] w_din;
  logic [31:0] w_data;
  logic        w_ok, w_req;
  logic [20:0] w_saddr;

  int n_cmp = 0;
  int n_bad = 0;
  int n_req = 0;

  always #5 clk = ~clk;

  jtkiwi_romslot #(.OFFSET(21'h10000)) dut (
    .clk(clk), .rst(rst), .rom_cs(cs), .rom_addr(addr), .rom_data(data),
    .rom_ok(ok), .sdram_req(req), .sdram_addr(saddr), .sdram_ack(ack),
    .sdram_dok(dok), .sdram_din(din)
  );

  jtkiwi_romslot #(.OFFSET(21'h1FFFFE)) dut_w (
    .clk(clk), .rst(rst), .rom_cs(w_cs), .rom_addr(w_addr), .rom_data(w_data),
    .rom_ok(w_ok), .sdram_req(w_req), .sdram_addr(w_saddr), .sdram_ack(w_ack),
    .sdram_dok(w_dok), .sdram_din(w_din)
  );

  // Accepted requests on the main instance
  always @(posedge clk) if (!rst && req && ack) n_req++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the main request line
  task automatic wait_req(input string tag);
    int n = 0;
    while (!req && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_req"}, 32'(req), 32'd1);
  endtask

  // Answer one main-instance request: ack after ack_wait cycles, then two beats
  task automatic serve(input int ack_wait, input logic [15:0] b0, input logic [15:0] b1,
                       input logic [20:0] exp_addr, input bit drop_cs, input string tag);
    wait_req(tag);
    check_eq({tag, "_addr"}, 32'(saddr), 32'(exp_addr));
    repeat (ack_wait) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    if (drop_cs) cs = 1'b0;
    dok = 1'b1;
    din = b0;
    tick();
    din = b1;
    tick();
    dok = 1'b0;
    din = 16'h0;
  endtask

  initial begin
    int base;
    int nw;
    rst = 1'b1; cs = 1'b1; addr = 18'h00123; ack = 1'b0; dok = 1'b0; din = 16'h0;
    w_cs = 1'b0; w_addr = 18'h0; w_ack = 1'b0; w_dok = 1'b0; w_din = 16'h0;

    // Reset held with rom_cs high
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_ok", 32'(ok), 32'd0);
      check_eq("rst_req", 32'(req), 32'd0);
    end
    check_eq("rst_data", data, 32'h0);
    check_eq("rst_saddr", 32'(saddr), 32'h0);
    rst = 1'b0;
    tick();
    check_eq("first_req", 32'(req), 32'd1);

    // Miss on 00123 with offset
    serve(0, 16'hBEEF, 16'hDEAD, 21'h10246, 1'b0, "miss");
    check_eq("miss_ok_pre", 32'(ok), 32'd0);
    tick();
    check_eq("miss_ok", 32'(ok), 32'd1);
    check_eq("miss_data", data, 32'hDEADBEEF);
    base = n_req;
    repeat (5) tick();
    check_eq("hold_ok", 32'(ok), 32'd1);
    check_eq("hold_data", data, 32'hDEADBEEF);
    check_eq("hold_noreq", 32'(n_req - base), 32'd0);

    // Single-entry cache: 00124 evicts 00123
    addr = 18'h00124;
    tick();
    check_eq("a124_ok_drop", 32'(ok), 32'd0);
    serve(2, 16'h1111, 16'h2222, 21'h10248, 1'b0, "a124");
    tick();
    check_eq("a124_ok", 32'(ok), 32'd1);
    check_eq("a124_data", data, 32'h22221111);
    addr = 18'h00123;
    tick();
    check_eq("back123_ok", 32'(ok), 32'd0);
    serve(0, 16'hBEEF, 16'hDEAD, 21'h10246, 1'b0, "back123");
    tick();
    check_eq("back123_ok2", 32'(ok), 32'd1);
    check_eq("back123_data", data, 32'hDEADBEEF);
    check_eq("evict_reqs", 32'(n_req - base), 32'd2);
    base = n_req;
    repeat (10) tick();
    check_eq("same_noreq", 32'(n_req - base), 32'd0);

    // Address change during BEAT0
    addr = 18'h00001;
    wait_req("chg1");
    check_eq("chg1_addr", 32'(saddr), 32'h10002);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    addr = 18'h00002;
    dok = 1'b1; din = 16'hAAAA;
    tick();
    check_eq("chg_ok_b1", 32'(ok), 32'd0);
    din = 16'hBBBB;
    tick();
    dok = 1'b0;
    check_eq("chg_ok_idle", 32'(ok), 32'd0);
    check_eq("chg_fill_data", data, 32'hBBBBAAAA);
    tick();
    check_eq("chg_ok_after", 32'(ok), 32'd0);
    serve(0, 16'h3333, 16'h4444, 21'h10004, 1'b0, "chg2");
    check_eq("chg2_ok_pre", 32'(ok), 32'd0);
    tick();
    check_eq("chg2_ok", 32'(ok), 32'd1);
    check_eq("chg2_data", data, 32'h44443333);

    // Backpressure: ack withheld for 20 cycles
    addr = 18'h00050;
    wait_req("bp");
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_req", 32'(req), 32'd1);
      check_eq("bp_addr", 32'(saddr), 32'h100A0);
      tick();
    end
    serve(0, 16'h5555, 16'h6666, 21'h100A0, 1'b0, "bp_end");
    tick();
    check_eq("bp_ok", 32'(ok), 32'd1);
    check_eq("bp_data", data, 32'h66665555);

    // rom_cs dropped mid-fetch: fill completes, no new request
    addr = 18'h00060;
    base = n_req;
    serve(0, 16'h7777, 16'h8888, 21'h100C0, 1'b1, "csdrop");
    repeat (3) tick();
    check_eq("csdrop_req", 32'(req), 32'd0);
    check_eq("csdrop_ok", 32'(ok), 32'd0);
    check_eq("csdrop_nreq", 32'(n_req - base), 32'd1);
    cs = 1'b1;
    tick();
    check_eq("csdrop_hit", 32'(ok), 32'd1);
    check_eq("csdrop_data", data, 32'h88887777);
    check_eq("csdrop_nreq2", 32'(n_req - base), 32'd1);

    // Wrap instance: fill 00001 at wrapped address 0
    w_cs = 1'b1; w_addr = 18'h00001;
    nw = 0;
    while (!w_req && nw < 50) begin tick(); nw++; end
    check_eq("wrap_req", 32'(w_req), 32'd1);
    check_eq("wrap_addr", 32'(w_saddr), 32'h000000);
    w_ack = 1'b1; tick(); w_ack = 1'b0;
    w_dok = 1'b1; w_din = 16'h9ABC; tick();
    w_din = 16'h1234; tick();
    w_dok = 1'b0;
    tick();
    check_eq("wrap_ok", 32'(w_ok), 32'd1);
    check_eq("wrap_data", w_data, 32'h12349ABC);

    // Reset during BEAT0 of a second fetch clears the cache
    w_addr = 18'h00002;
    nw = 0;
    while (!w_req && nw < 50) begin tick(); nw++; end
    check_eq("wrap2_addr", 32'(w_saddr), 32'h000002);
    w_ack = 1'b1; tick(); w_ack = 1'b0;
    rst = 1'b1; w_addr = 18'h00001;
    tick();
    check_eq("rstmid_ok", 32'(w_ok), 32'd0);
    check_eq("rstmid_req", 32'(w_req), 32'd0);
    check_eq("rstmid_data", w_data, 32'h0);
    rst = 1'b0;
    tick();
    check_eq("rstmid_miss_req", 32'(w_req), 32'd1);
    check_eq("rstmid_miss_addr", 32'(w_saddr), 32'h000000);
    check_eq("rstmid_miss_ok", 32'(w_ok), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
